// File: rtl/gth_link_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : gth_link_seq_if
//  Description : Control/status bundle between the GTH link sequencer and
//                the logic around it (enable, restart, transceiver status,
//                transceiver reset, link state reporting).
//                Optional macro GTH_LINK_SEQ_LOSS_CNT_EN adds loss_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
interface gth_link_seq_if;
   logic        en;
   logic        restart;
   logic [3:0]  status;
   logic        rxclk_vld;
   logic        gth_rst;
   logic        link_up;
   logic        fail;
   logic [7:0]  retry_cnt;
   logic [2:0]  state;
`ifdef GTH_LINK_SEQ_LOSS_CNT_EN
   logic [15:0] loss_cnt;
`endif

   // Sequencer side
   modport slave (
      input  en,
      input  restart,
      input  status,
      input  rxclk_vld,
      output gth_rst,
      output link_up,
      output fail,
      output retry_cnt,
`ifdef GTH_LINK_SEQ_LOSS_CNT_EN
      output loss_cnt,
`endif
      output state
   );

   // Controlling side (software bridge / testbench)
   modport master (
      output en,
      output restart,
      output status,
      output rxclk_vld,
      input  gth_rst,
      input  link_up,
      input  fail,
      input  retry_cnt,
`ifdef GTH_LINK_SEQ_LOSS_CNT_EN
      input  loss_cnt,
`endif
      input  state
   );
endinterface
`default_nettype wire

// File: rtl/gth_link_seq.sv
`default_nettype none
// ============================================================================
//  Module      : gth_link_seq
//  Description : Bring-up and supervision sequencer for the SFP0 GTH
//                transceiver. Holds the transceiver in reset, waits for PLL
//                lock, reset-done/CDR lock and a stable recovered clock,
//                retries with timeouts and reports link state.
//                Optional macro GTH_LINK_SEQ_LOSS_CNT_EN adds a saturating
//                count of link losses (loss_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module gth_link_seq #(
   parameter int unsigned RST_HOLD   = 32,
   parameter int unsigned LOCK_TO    = 250000,
   parameter int unsigned STABLE_CYC = 1024,
   parameter int unsigned MAX_RETRY  = 8
) (
   input  wire logic       clk,
   input  wire logic       rst,
   gth_link_seq_if.slave   lnk
);

   // The shared timer times both the reset hold and the wait-state timeouts.
   localparam int unsigned TMR_MAX = (LOCK_TO > RST_HOLD) ? LOCK_TO : RST_HOLD;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam int unsigned STB_W   = $clog2(STABLE_CYC + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_PLL  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_WAIT_CLK  = 3'd4,
      ST_UP        = 3'd5,
      ST_FAIL      = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [STB_W-1:0]   stab_q, stab_d;
   logic [7:0]         retry_q, retry_d;

   logic [3:0]         status_m_q, status_s_q;
   logic               rxclk_m_q, rxclk_s_q;

   logic [TMR_W-1:0]   timer_inc;
   logic [7:0]         retry_inc;
   logic               timeout;
   logic               attempt_fail;

   // Two-flop synchronizers for the asynchronous transceiver status.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_m_q <= 4'd0;
         status_s_q <= 4'd0;
         rxclk_m_q  <= 1'b0;
         rxclk_s_q  <= 1'b0;
      end else begin
         status_m_q <= lnk.status;
         status_s_q <= status_m_q;
         rxclk_m_q  <= lnk.rxclk_vld;
         rxclk_s_q  <= rxclk_m_q;
      end
   end

   // Saturating increments; every counter stops at its terminal value.
   assign timer_inc = (timer_q == TMR_W'(TMR_MAX)) ? timer_q : timer_q + 1'b1;
   assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
   assign timeout   = (timer_q >= TMR_W'(LOCK_TO - 1));

   // Next-state, counter and retry decisions.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      stab_d       = stab_q;
      retry_d      = retry_q;
      attempt_fail = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (lnk.en) state_d = ST_RESET;
         end
         ST_RESET: begin
            if (timer_q >= TMR_W'(RST_HOLD - 1)) state_d = ST_WAIT_PLL;
            else                                  timer_d = timer_inc;
         end
         ST_WAIT_PLL: begin
            if (status_s_q[0])  state_d      = ST_WAIT_DONE;
            else if (timeout)   attempt_fail = 1'b1;
            else                timer_d      = timer_inc;
         end
         ST_WAIT_DONE: begin
            if (&status_s_q[3:1]) state_d      = ST_WAIT_CLK;
            else if (timeout)     attempt_fail = 1'b1;
            else                  timer_d      = timer_inc;
         end
         ST_WAIT_CLK: begin
            if (rxclk_s_q && (stab_q >= STB_W'(STABLE_CYC - 1))) begin
               state_d = ST_UP;
               retry_d = 8'd0;
            end else if (timeout) begin
               attempt_fail = 1'b1;
            end else begin
               timer_d = timer_inc;
               // A single low cycle restarts the stability window.
               stab_d  = rxclk_s_q ? stab_q + 1'b1 : '0;
            end
         end
         ST_UP: begin
            if (!status_s_q[0] || !status_s_q[3] || !rxclk_s_q) state_d = ST_RESET;
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (attempt_fail) begin
         retry_d = retry_inc;
         state_d = (retry_inc >= 8'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
      end

      // restart beats timeout/success; en=0 beats restart.
      if (lnk.restart) begin
         state_d = ST_RESET;
         retry_d = 8'd0;
      end
      if (!lnk.en) begin
         state_d = ST_IDLE;
         retry_d = 8'd0;
      end

      // Timers start from zero on every state entry and on forced moves.
      if ((state_d != state_q) || lnk.restart || !lnk.en) begin
         timer_d = '0;
         stab_d  = '0;
      end
   end

   // State, timer and retry registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         stab_q  <= '0;
         retry_q <= 8'd0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         stab_q  <= stab_d;
         retry_q <= retry_d;
      end
   end

   assign lnk.gth_rst   = (state_q == ST_IDLE) || (state_q == ST_RESET) || (state_q == ST_FAIL);
   assign lnk.link_up   = (state_q == ST_UP);
   assign lnk.fail      = (state_q == ST_FAIL);
   assign lnk.retry_cnt = retry_q;
   assign lnk.state     = state_q;

`ifdef GTH_LINK_SEQ_LOSS_CNT_EN
   logic [15:0] loss_q;
   logic        loss_ev;

   // A loss is an UP->RESET move that was not forced by restart or en=0.
   assign loss_ev = (state_q == ST_UP) && (state_d == ST_RESET) && lnk.en && !lnk.restart;

   // Saturating loss counter; survives en=0, cleared by restart.
   always_ff @(posedge clk) begin
      if (rst || lnk.restart)               loss_q <= 16'd0;
      else if (loss_ev && (loss_q != 16'hFFFF)) loss_q <= loss_q + 16'd1;
   end

   assign lnk.loss_cnt = loss_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gth_link_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gth_link_seq
//  Description : Self-checking bench for gth_link_seq. A table of stimulus
//                steps with expected outputs drives the sequencer through
//                bring-up, timeouts, FAIL, restart, loss and disruptions;
//                expectations pass through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gth_link_seq;

   logic clk = 1'b0;
   logic rst;

   gth_link_seq_if lnk_if ();

   gth_link_seq #(
      .RST_HOLD   (4),
      .LOCK_TO    (100),
      .STABLE_CYC (8),
      .MAX_RETRY  (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .lnk (lnk_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic        en;
      logic        restart;
      logic [3:0]  status;
      logic        rxclk;
      int          n;
      logic [2:0]  st;
      logic        gr;
      logic        lu;
      logic        fl;
      logic [7:0]  rc;
      logic [15:0] lc;
   } vec_t;

   typedef struct {
      string       name;
      logic [13:0] outs;
      logic [15:0] lc;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic add(input string nm, input logic r, input logic e, input logic rs,
                      input logic [3:0] s, input logic rx, input int n,
                      input logic [2:0] st, input logic gr, input logic lu,
                      input logic fl, input logic [7:0] rc, input logic [15:0] lc);
      vec_t v;
      v.name = nm; v.rst = r; v.en = e; v.restart = rs; v.status = s; v.rxclk = rx;
      v.n = n; v.st = st; v.gr = gr; v.lu = lu; v.fl = fl; v.rc = rc; v.lc = lc;
      vt.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
   endtask

   initial begin
      exp_t e;
      int   lat;
      int   rst_hi;
      bit   seen;

      rst = 1'b1;
      lnk_if.en = 1'b0; lnk_if.restart = 1'b0;
      lnk_if.status = 4'hF; lnk_if.rxclk_vld = 1'b1;

      //   name            rst en rs stat rx  n    st gr lu fl rc lc
      add("reset_state",   1, 0, 0, 4'hF, 1,   3, 0, 1, 0, 0, 0, 0);
      add("idle_no_en",    0, 0, 0, 4'hF, 1,   3, 0, 1, 0, 0, 0, 0);
      add("nom_reset",     0, 1, 0, 4'hF, 1,   1, 1, 1, 0, 0, 0, 0);
      add("nom_rst_hold",  0, 1, 0, 4'hF, 1,   3, 1, 1, 0, 0, 0, 0);
      add("nom_wpll",      0, 1, 0, 4'hF, 1,   1, 2, 0, 0, 0, 0, 0);
      add("nom_wdone",     0, 1, 0, 4'hF, 1,   1, 3, 0, 0, 0, 0, 0);
      add("nom_wclk",      0, 1, 0, 4'hF, 1,   1, 4, 0, 0, 0, 0, 0);
      add("nom_pre_up",    0, 1, 0, 4'hF, 1,   7, 4, 0, 0, 0, 0, 0);
      add("nom_up",        0, 1, 0, 4'hF, 1,   1, 5, 0, 1, 0, 0, 0);
      add("nom_up_hold",   0, 1, 0, 4'hF, 1,  20, 5, 0, 1, 0, 0, 0);
      add("loss_drop",     0, 1, 0, 4'h7, 1,   1, 5, 0, 1, 0, 0, 0);
      add("loss_restore",  0, 1, 0, 4'hF, 1,   1, 5, 0, 1, 0, 0, 0);
      add("loss_reset",    0, 1, 0, 4'hF, 1,   1, 1, 1, 0, 0, 0, 1);
      add("loss_wpll",     0, 1, 0, 4'hF, 1,   4, 2, 0, 0, 0, 0, 1);
      add("relock_up",     0, 1, 0, 4'hF, 1,  10, 5, 0, 1, 0, 0, 1);
      add("gl_restart",    0, 1, 1, 4'hF, 1,   1, 1, 1, 0, 0, 0, 0);
      add("gl_wclk",       0, 1, 0, 4'hF, 1,   8, 4, 0, 0, 0, 0, 0);
      add("gl_low",        0, 1, 0, 4'hF, 0,   1, 4, 0, 0, 0, 0, 0);
      add("gl_pre_up",     0, 1, 0, 4'hF, 1,   9, 4, 0, 0, 0, 0, 0);
      add("gl_up",         0, 1, 0, 4'hF, 1,   1, 5, 0, 1, 0, 0, 0);
      add("pll_rst",       1, 0, 0, 4'h0, 0,   2, 0, 1, 0, 0, 0, 0);
      add("pll_en",        0, 1, 0, 4'h0, 0,   5, 2, 0, 0, 0, 0, 0);
      add("pll_pre_to1",   0, 1, 0, 4'h0, 0,  99, 2, 0, 0, 0, 0, 0);
      add("pll_to1",       0, 1, 0, 4'h0, 0,   1, 1, 1, 0, 0, 1, 0);
      add("pll_to2",       0, 1, 0, 4'h0, 0, 104, 1, 1, 0, 0, 2, 0);
      add("pll_fail",      0, 1, 0, 4'h0, 0, 104, 6, 1, 0, 1, 3, 0);
      add("fail_hold",     0, 1, 0, 4'h0, 0,  50, 6, 1, 0, 1, 3, 0);
      add("fail_stat_ok",  0, 1, 0, 4'hF, 1,   5, 6, 1, 0, 1, 3, 0);
      add("fail_restart",  0, 1, 1, 4'hF, 1,   1, 1, 1, 0, 0, 0, 0);
      add("fail_relink",   0, 1, 0, 4'hF, 1,  14, 5, 0, 1, 0, 0, 0);
      add("wd_restart",    0, 1, 1, 4'h1, 1,   1, 1, 1, 0, 0, 0, 0);
      add("wd_enter",      0, 1, 0, 4'h1, 1,   5, 3, 0, 0, 0, 0, 0);
      add("wd_dwell",      0, 1, 0, 4'h1, 1,  10, 3, 0, 0, 0, 0, 0);
      add("wd_en_low",     0, 0, 0, 4'h1, 1,   1, 0, 1, 0, 0, 0, 0);
      add("en_vs_restart", 0, 0, 1, 4'h1, 1,   1, 0, 1, 0, 0, 0, 0);
      add("wd_again",      0, 1, 0, 4'h1, 1,   6, 3, 0, 0, 0, 0, 0);
      add("wd_rst",        1, 1, 0, 4'h1, 1,   1, 0, 1, 0, 0, 0, 0);
      add("wd_rel",        0, 1, 0, 4'h1, 1,   6, 3, 0, 0, 0, 0, 0);
      add("wd_pre_to",     0, 1, 0, 4'h1, 1,  99, 3, 0, 0, 0, 0, 0);
      add("wd_to",         0, 1, 0, 4'h1, 1,   1, 1, 1, 0, 0, 1, 0);

      foreach (vt[i]) begin
         rst              = vt[i].rst;
         lnk_if.en        = vt[i].en;
         lnk_if.restart   = vt[i].restart;
         lnk_if.status    = vt[i].status;
         lnk_if.rxclk_vld = vt[i].rxclk;
         e.name = vt[i].name;
         e.outs = {vt[i].st, vt[i].gr, vt[i].lu, vt[i].fl, vt[i].rc};
         e.lc   = vt[i].lc;
         sb.push_back(e);
         tick();
         // restart is a single-cycle pulse
         lnk_if.restart = 1'b0;
         for (int k = 1; k < vt[i].n; k++) tick();
         e = sb.pop_front();
         check(e.name, 32'({lnk_if.state, lnk_if.gth_rst, lnk_if.link_up,
                            lnk_if.fail, lnk_if.retry_cnt}), 32'(e.outs));
`ifdef GTH_LINK_SEQ_LOSS_CNT_EN
         check({e.name, "_loss_cnt"}, 32'(lnk_if.loss_cnt), 32'(e.lc));
`endif
      end

      // Hand-written: bring-up latency and reset-hold length, bounded wait.
      rst = 1'b1; lnk_if.en = 1'b0; lnk_if.restart = 1'b0;
      lnk_if.status = 4'hF; lnk_if.rxclk_vld = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      lnk_if.en = 1'b1;
      lat = 0; rst_hi = 0; seen = 1'b0;
      for (int k = 1; k <= 200 && !seen; k++) begin
         tick();
         if (lnk_if.gth_rst) rst_hi++;
         if (lnk_if.link_up) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      if (!seen) begin
         n_total++;
         $display("FAIL link_up_timeout: link_up not seen within 200 cycles, required at 15");
      end else begin
         check("up_latency", 32'(lat), 32'd15);
         check("gth_rst_cycles", 32'(rst_hi), 32'd4);
      end

      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_left: %0d entries remain, required 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
